drm_34x256_fifo_ctrl: RTL
=========================

# drm_34x256_fifo_ctrl

Single-clock FIFO controller that sits directly in front of the `drm_34x256` simple dual-port RAM (34-bit, 256-deep, unregistered output, one-cycle read latency). It generates the RAM write/read addresses and write enable, and prefetches RAM output into a 2-entry output buffer to present a first-word-fall-through valid/ready stream. Total capacity is 258 words; full throughput is one word per cycle in and out.

## Interface
- `DATA_WIDTH`, 34, word width; must match the RAM data width.
- `ADDR_WIDTH`, 8, RAM address width; RAM depth = 2**ADDR_WIDTH.
- `clk`  in  1  single clock for FIFO and RAM (drives both RAM `wr_clk` and `rd_clk`).
- `rst`  in  1  asynchronous, active-high reset; also drives RAM `wr_rst`/`rd_rst`.
- `s_data`  in  DATA_WIDTH  write-side data.
- `s_valid`  in  1  write request.
- `s_ready`  out  1  write accepted when `s_valid && s_ready`.
- `m_data`  out  DATA_WIDTH  head word.
- `m_valid`  out  1  head word valid.
- `m_ready`  in  1  pop when `m_valid && m_ready`.
- `ram_wr_data`  out  DATA_WIDTH  to RAM `wr_data` (= `s_data`).
- `ram_wr_addr`  out  ADDR_WIDTH  to RAM `wr_addr` (= `wr_ptr[ADDR_WIDTH-1:0]`).
- `ram_wr_en`  out  1  to RAM `wr_en` (= push).
- `ram_rd_addr`  out  ADDR_WIDTH  to RAM `rd_addr` (= `rd_ptr[ADDR_WIDTH-1:0]`).
- `ram_rd_data`  in  DATA_WIDTH  from RAM `rd_data`.
- `level`  out  ADDR_WIDTH+1  total words held (RAM + in-flight + buffer), 0..258.

## Operation
- Pointers `wr_ptr`, `rd_ptr` are ADDR_WIDTH+1 bits (extra wrap bit); `ram_count` = `wr_ptr - rd_ptr`, 0..256.
- push = `s_valid && s_ready`; `s_ready` = `!rst && ram_count != 256`. Push: RAM write at `wr_ptr`, `wr_ptr` +1 (mod 512).
- pop = `m_valid && m_ready`.
- issue = `ram_count != 0 && (buf_cnt + inflight - pop) < 2`. On issue the RAM samples `rd_ptr` at this edge, `rd_ptr` +1, `inflight` <= 1; otherwise `inflight` <= 0.
- When `inflight` = 1, `ram_rd_data` is written into the output buffer at the next edge (tail slot after any same-cycle pop).
- Output buffer: 2 registers, head/second; `buf_cnt` 0..2; pop shifts second into head. `m_valid` = `buf_cnt != 0`; `m_data` = head.
- `ram_count` uses registered value only; a read is never issued to the address being written in the same cycle. A word written at edge N is readable by an issue at edge N+1.
- Simultaneous push and issue: `ram_count` unchanged. Pointer wrap at 256 handled by the extra bit.
- No bypass path: every word passes through the RAM.

## Timing
- Reset values: `wr_ptr`=`rd_ptr`=0, `inflight`=0, `buf_cnt`=0, `m_valid`=0, `m_data`=0, `level`=0, `ram_wr_en`=0, `s_ready`=0 while `rst` is high, 1 the cycle after release.
- Latency: push at edge 0 -> issue at edge 1 -> `m_valid`=1 after edge 2.
- Steady state with `m_ready`=1: one push and one pop per cycle, `buf_cnt`=1, `inflight`=1.
- Full: with `m_ready`=0, exactly 258 pushes accepted, then `s_ready`=0; one pop re-asserts `s_ready` within 2 cycles.
- `rst` mid-operation: all contents discarded asynchronously; RAM contents are stale and never read.

## Configuration
- `DRM_FIFO_LEVEL_EN`: defined -> `level` computed as `ram_count + inflight + buf_cnt`, registered. Undefined -> `level` tied to 0 and its counter logic removed; all other behaviour identical.

## Test plan
- Reset then single push of 34'h3_FFFF_FFFF -> `m_valid` rises after edge 2, `m_data`=34'h3_FFFF_FFFF, `level`=1 (macro on).
- `m_ready`=0, push down-counting data from 34'h3_FFFF_FFFF -> 258 accepted, `s_ready`=0, `level`=258; drain -> 258 words in order, then `m_valid`=0, `level`=0.
- `m_ready`=1, continuous 600-word push -> one pop per cycle after 2-cycle start-up, data in order across two pointer wraps.
- Random `s_valid`/`m_ready` (50%) for 5000 cycles -> scoreboard match, no loss or duplicate, `level` never > 258.
- Full FIFO, assert `rst` mid-drain -> `m_valid`=0, `level`=0 immediately; new push after release returns only the new word.
- Build without `DRM_FIFO_LEVEL_EN` -> `level` constant 0, data scenarios above still pass.

Source files
------------

// File: rtl/drm_34x256_fifo_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// drm_34x256_fifo_ctrl
//
// Single-clock FIFO controller for the drm_34x256 simple dual-port RAM
// (34-bit x 256, unregistered output, one-cycle read latency). Generates the
// RAM addresses and write enable, and prefetches RAM output into a 2-entry
// output buffer so the read side is a first-word-fall-through valid/ready
// stream. Capacity is 256 (RAM) + 2 (buffer) = 258 words. Every word passes
// through the RAM; there is no write-to-read bypass.
//
// Ports:
//   clk          single clock for controller and RAM (both RAM clocks)
//   rst          asynchronous active-high reset (also to RAM wr_rst/rd_rst)
//   s_data       write-side data
//   s_valid      write request
//   s_ready      write accepted when s_valid && s_ready
//   m_data       head word
//   m_valid      head word valid
//   m_ready      pop when m_valid && m_ready
//   ram_wr_data  to RAM wr_data (= s_data)
//   ram_wr_addr  to RAM wr_addr
//   ram_wr_en    to RAM wr_en (= push)
//   ram_rd_addr  to RAM rd_addr
//   ram_rd_data  from RAM rd_data
//   level        total words held (RAM + in flight + buffer), 0..258
//
// Build option:
//   DRM_FIFO_LEVEL_EN  defined   -> level is a registered occupancy count
//                      undefined -> level is tied to 0
// -----------------------------------------------------------------------------
module drm_34x256_fifo_ctrl #(
  parameter int DATA_WIDTH = 34,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic [ADDR_WIDTH:0]   level
);

  localparam logic [ADDR_WIDTH:0] RAM_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] PTR_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic [ADDR_WIDTH:0]   ram_count;
  logic                  inflight;
  logic [1:0]            buf_cnt;
  logic [1:0]            buf_base;
  logic [2:0]            occ_after_pop;
  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] second;
  logic                  push;
  logic                  pop;
  logic                  issue;

  // Extra wrap bit makes the difference 0..256 without a separate full flag.
  assign ram_count = wr_ptr - rd_ptr;

  assign s_ready = !rst && (ram_count != RAM_DEPTH);
  assign push    = s_valid && s_ready;
  assign m_valid = (buf_cnt != 2'd0);
  assign pop     = m_valid && m_ready;
  assign m_data  = head;

  // Words already owned by the buffer once this cycle's pop is taken out,
  // counting the one arriving from the RAM. A new read is issued only if its
  // data will have a free slot when it lands next cycle.
  assign occ_after_pop = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign issue         = (ram_count != '0) && (occ_after_pop < 3'd2);

  // Slot that the arriving RAM word lands in (tail after the pop shift).
  assign buf_base = buf_cnt - {1'b0, pop};

  assign ram_wr_data = s_data;
  assign ram_wr_addr = wr_ptr[ADDR_WIDTH-1:0];
  assign ram_wr_en   = push;
  assign ram_rd_addr = rd_ptr[ADDR_WIDTH-1:0];

  // ---- stage p0: pointers; RAM samples rd_addr at this edge on issue ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      inflight <= 1'b0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + PTR_ONE;
      if (issue) rd_ptr <= rd_ptr + PTR_ONE;
      inflight <= issue;
    end
  end

  // ---- stage p1: RAM output captured into the 2-entry output buffer ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_cnt <= 2'd0;
      head    <= '0;
    end else begin
      buf_cnt <= buf_base + {1'b0, inflight};
      if (inflight && (buf_base == 2'd0)) begin
        head <= ram_rd_data;
      end else if (pop && (buf_cnt == 2'd2)) begin
        head <= second;
      end
    end
  end

  // Second slot is pure data; its contents are only used while buf_cnt says so.
  always_ff @(posedge clk) begin
    if (inflight && (buf_base == 2'd1)) begin
      second <= ram_rd_data;
    end
  end

`ifdef DRM_FIFO_LEVEL_EN
  logic [ADDR_WIDTH:0] level_q;

  // Running count of pushes minus pops equals ram_count + inflight + buf_cnt
  // after each edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= '0;
    end else begin
      level_q <= level_q + {{ADDR_WIDTH{1'b0}}, push} - {{ADDR_WIDTH{1'b0}}, pop};
    end
  end

  assign level = level_q;
`else
  assign level = '0;
`endif

endmodule
